// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the unified-RAM port arbiter.
// FSM states, requester ids and bus widths.
package mem_port_arbiter_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int SEL_W  = 4;

  localparam logic [SEL_W-1:0] SEL_WORD = 4'b1111;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_RESP   = 2'd2
  } arb_state_e;

  typedef enum logic {
    ARB_ID_INST = 1'b0,
    ARB_ID_DATA = 1'b1
  } arb_id_e;

endpackage

// File: rtl/mem_port_arbiter_pick2.sv
// Two-way grant picker for the RAM port arbiter.
// MEM_ARB_RR_EN selects round-robin, else data wins.
module arb_pick2
  import mem_port_arbiter_pkg::*;
(
  input  logic    inst_req,
  input  logic    data_req,
  input  arb_id_e last_grant,
  output arb_id_e grant
);

`ifdef MEM_ARB_RR_EN
  // On a tie, favour whoever was not granted last
  always_comb begin
    grant = ARB_ID_DATA;
    if (inst_req && data_req)
      grant = (last_grant == ARB_ID_INST) ?
              ARB_ID_DATA : ARB_ID_INST;
    else if (inst_req)
      grant = ARB_ID_INST;
  end
`else
  logic unused_last;
  assign unused_last = last_grant;

  // Data always beats instruction fetch
  assign grant = (data_req || !inst_req) ?
                 ARB_ID_DATA : ARB_ID_INST;
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single-port RAM between IF and MEM.
// MEM_ARB_RR_EN enables round-robin arbitration.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int WAIT_CYCLES = 1,
  parameter int CNT_WIDTH   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic              inst_ack,
  output logic [DATA_W-1:0] inst_rdata,
  input  logic              data_req,
  input  logic              data_we,
  input  logic [SEL_W-1:0]  data_sel,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_ack,
  output logic [DATA_W-1:0] data_rdata,
  output logic              ram_en,
  output logic [SEL_W-1:0]  ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              stall_req,
  output logic              busy
);

  arb_state_e           state;
  arb_id_e              cur_id;
  arb_id_e              grant;
  arb_id_e              last_grant;
  logic [CNT_WIDTH-1:0] cnt;
  logic                 is_store;

  logic unused_bits;
  assign unused_bits = ^{inst_addr[1:0], data_addr[1:0]};

  assign stall_req = (inst_req & ~inst_ack) |
                     (data_req & ~data_ack);

  arb_pick2 u_pick (
    .inst_req  (inst_req),
    .data_req  (data_req),
    .last_grant(last_grant),
    .grant     (grant)
  );

`ifdef MEM_ARB_RR_EN
  // Remember the most recent winner for round-robin
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      last_grant <= ARB_ID_INST;
    else if (state == ARB_IDLE && (inst_req || data_req))
      last_grant <= grant;
  end
`else
  assign last_grant = ARB_ID_INST;
`endif

  // Grant, drive the RAM for the wait count, then ack
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ARB_IDLE;
      cur_id     <= ARB_ID_INST;
      cnt        <= '0;
      is_store   <= 1'b0;
      busy       <= 1'b0;
      inst_ack   <= 1'b0;
      data_ack   <= 1'b0;
      inst_rdata <= '0;
      data_rdata <= '0;
      ram_en     <= 1'b0;
      ram_we     <= '0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
    end else begin
      inst_ack <= 1'b0;
      data_ack <= 1'b0;
      unique case (state)
        ARB_IDLE: begin
          if (inst_req || data_req) begin
            state  <= ARB_ACCESS;
            busy   <= 1'b1;
            ram_en <= 1'b1;
            cur_id <= grant;
            cnt    <= CNT_WIDTH'(WAIT_CYCLES);
            if (grant == ARB_ID_DATA) begin
              ram_addr  <= {data_addr[ADDR_W-1:2], 2'b00};
              ram_wdata <= data_wdata;
              ram_we    <= data_we ? data_sel : '0;
              is_store  <= data_we;
            end else begin
              ram_addr  <= {inst_addr[ADDR_W-1:2], 2'b00};
              ram_wdata <= '0;
              ram_we    <= '0;
              is_store  <= 1'b0;
            end
          end
        end
        ARB_ACCESS: begin
          if (cnt == '0) begin
            state  <= ARB_RESP;
            ram_en <= 1'b0;
            ram_we <= '0;
            if (cur_id == ARB_ID_DATA) begin
              data_ack   <= 1'b1;
              data_rdata <= is_store ? '0 : ram_rdata;
            end else begin
              inst_ack   <= 1'b1;
              inst_rdata <= ram_rdata;
            end
          end else begin
            cnt <= cnt - CNT_WIDTH'(1);
          end
        end
        ARB_RESP: begin
          state <= ARB_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= ARB_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
